// File: rtl/baser_arb_pkg.sv
// Shared types and constants for the BASE-R checker-port arbiter.
package baser_arb_pkg;

  localparam int LANES       = 4;
  localparam int FRAME_WIDTH = 66;
  localparam int BEAT_WIDTH  = LANES * FRAME_WIDTH;
  localparam int CNT_WIDTH   = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/baser_checker_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request at or after i_ptr, wrapping.
// Purely combinational, no backpressure.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_onehot,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  localparam logic [IDW:0] NW = (IDW+1)'(N);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_pos;

  // Walk from the farthest offset down so the nearest request wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_pos    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_sum = {1'b0, i_ptr} + (IDW+1)'(i);
      w_pos = (w_sum >= NW) ? IDW'(w_sum - NW) : IDW'(w_sum);
      if (i_req[w_pos]) begin
        o_any           = 1'b1;
        o_idx           = w_pos;
        o_onehot        = '0;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/baser_checker_arbiter.sv
// Round-robin share of one 4x66b checker port among NUM_REQ sources; 1-cycle registered output, one IDLE bubble per grant.
// Ready stalls while a beat is pending unaccepted; ARB_TIMEOUT_EN adds an idle-valid watchdog release and o_timeout.
module baser_checker_arbiter
  import baser_arb_pkg::*;
#(
  parameter int FRAME_WIDTH = 66,
  parameter int LANES       = 4,
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT     = 32
) (
  input  logic                               clk,
  input  logic                               i_rst,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ-1:0]                 i_req_last,
  input  logic [NUM_REQ*LANES*FRAME_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic [FRAME_WIDTH-1:0]             o_rx_coded_0,
  output logic [FRAME_WIDTH-1:0]             o_rx_coded_1,
  output logic [FRAME_WIDTH-1:0]             o_rx_coded_2,
  output logic [FRAME_WIDTH-1:0]             o_rx_coded_3,
  output logic                               o_rx_valid,
  input  logic                               i_chk_ready,
  output logic [NUM_REQ-1:0]                 o_grant,
  output logic [$clog2(NUM_REQ)-1:0]         o_grant_id,
  output logic [CNT_WIDTH-1:0]               o_beat_count,
  output logic [CNT_WIDTH-1:0]               o_switch_count
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                               o_timeout
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = LANES * FRAME_WIDTH;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 ||
      TIMEOUT < 1 || LANES != 4) begin : g_param_chk
    $error("baser_checker_arbiter: parameter out of range");
  end

  arb_state_e             r_state;
  logic [IDW-1:0]         r_ptr;
  logic [NUM_REQ-1:0]     r_grant;
  logic [IDW-1:0]         r_grant_id;
  logic [7:0]             r_burst;
  logic                   r_rx_valid;
  logic [FRAME_WIDTH-1:0] r_lane [LANES];
  logic [CNT_WIDTH-1:0]   r_beat_count;
  logic [CNT_WIDTH-1:0]   r_switch_count;

  logic [NUM_REQ-1:0]     w_pick_onehot;
  logic [IDW-1:0]         w_pick_idx;
  logic                   w_pick_any;
  logic                   w_xfer;
  logic                   w_release;
  logic                   w_timeout;
  logic [BW-1:0]          w_sel_data;
  logic [IDW-1:0]         w_ptr_next;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .i_req    (i_req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Ready opens only when the output register is empty or draining this cycle.
  assign o_req_ready = (r_state == ARB_GRANT && (!r_rx_valid || i_chk_ready)) ? r_grant : '0;
  assign w_xfer      = |(i_req_valid & o_req_ready);
  assign w_sel_data  = i_req_data[r_grant_id*BW +: BW];
  assign w_ptr_next  = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDW'(1);
  assign w_release   = (w_xfer && (i_req_last[r_grant_id] || r_burst == 8'(MAX_BURST - 1)))
                       || w_timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);

  logic [TOW-1:0] r_idle_cnt;
  logic           w_gvld;

  assign w_gvld    = |(i_req_valid & r_grant);
  assign w_timeout = (r_state == ARB_GRANT) && !w_gvld && (r_idle_cnt == TOW'(TIMEOUT - 1));
  assign o_timeout = w_timeout;

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_idle_cnt <= '0;
    end else if (r_state != ARB_GRANT || w_gvld || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TOW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_state        <= ARB_IDLE;
      r_ptr          <= '0;
      r_grant        <= '0;
      r_grant_id     <= '0;
      r_burst        <= '0;
      r_rx_valid     <= 1'b0;
      r_beat_count   <= '0;
      r_switch_count <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_lane[k] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_rx_valid <= 1'b1;
        for (int k = 0; k < LANES; k++) begin
          r_lane[k] <= w_sel_data[k*FRAME_WIDTH +: FRAME_WIDTH];
        end
      end else if (i_chk_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (r_rx_valid && i_chk_ready) begin
        r_beat_count <= r_beat_count + CNT_WIDTH'(1);
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_state        <= ARB_GRANT;
            r_grant        <= w_pick_onehot;
            r_grant_id     <= w_pick_idx;
            r_burst        <= '0;
            r_switch_count <= r_switch_count + CNT_WIDTH'(1);
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_burst <= '0;
          end else if (w_xfer) begin
            r_burst <= r_burst + 8'd1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_rx_coded_0   = r_lane[0];
  assign o_rx_coded_1   = r_lane[1];
  assign o_rx_coded_2   = r_lane[2];
  assign o_rx_coded_3   = r_lane[3];
  assign o_rx_valid     = r_rx_valid;
  assign o_grant        = r_grant;
  assign o_grant_id     = r_grant_id;
  assign o_beat_count   = r_beat_count;
  assign o_switch_count = r_switch_count;

endmodule

// File: tb/tb_baser_checker_arbiter.sv
// Directed bench for baser_checker_arbiter: round-robin table plus burst, stall and reset sequences.
module tb_baser_checker_arbiter;

  localparam int FW = 66;
  localparam int LN = 4;
  localparam int NR = 4;
  localparam int BW = FW * LN;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     i_req_last;
  logic [NR*BW-1:0]  i_req_data;
  logic [NR-1:0]     o_req_ready;
  logic [FW-1:0]     o_rx_coded_0, o_rx_coded_1, o_rx_coded_2, o_rx_coded_3;
  logic              o_rx_valid;
  logic              i_chk_ready;
  logic [NR-1:0]     o_grant;
  logic [1:0]        o_grant_id;
  logic [31:0]       o_beat_count;
  logic [31:0]       o_switch_count;
`ifdef ARB_TIMEOUT_EN
  logic              o_timeout;
`endif

  baser_checker_arbiter dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .i_req_last     (i_req_last),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .o_rx_coded_0   (o_rx_coded_0),
    .o_rx_coded_1   (o_rx_coded_1),
    .o_rx_coded_2   (o_rx_coded_2),
    .o_rx_coded_3   (o_rx_coded_3),
    .o_rx_valid     (o_rx_valid),
    .i_chk_ready    (i_chk_ready),
    .o_grant        (o_grant),
    .o_grant_id     (o_grant_id),
    .o_beat_count   (o_beat_count),
    .o_switch_count (o_switch_count)
`ifdef ARB_TIMEOUT_EN
    ,
    .o_timeout      (o_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic        rdy;
    logic [3:0]  grant;
    logic [1:0]  gid;
    logic        rxv;
    logic [65:0] lane0;
    logic [31:0] beats;
    logic [31:0] sw;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] grant, input logic [1:0] gid,
                              input logic rxv, input logic [65:0] lane0,
                              input logic [31:0] beats, input logic [31:0] sw);
    vec_t v;
    v.vld = vld; v.lst = 4'hF; v.rdy = 1'b1;
    v.grant = grant; v.gid = gid; v.rxv = rxv; v.lane0 = lane0; v.beats = beats; v.sw = sw;
    return v;
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int r, input logic [65:0] base);
    for (int k = 0; k < LN; k++) i_req_data[r*BW + k*FW +: FW] = base + 66'(k);
  endtask

  initial begin
    i_rst = 1'b0; i_req_valid = '0; i_req_last = '0; i_req_data = '0; i_chk_ready = 1'b1;
    tick; tick;
    check("rst_grant", o_grant, 0);
    check("rst_gid", o_grant_id, 0);
    check("rst_rxv", o_rx_valid, 0);
    check("rst_lane0", o_rx_coded_0, 0);
    check("rst_lane3", o_rx_coded_3, 0);
    check("rst_beats", o_beat_count, 0);
    check("rst_sw", o_switch_count, 0);
    check("rst_ready", o_req_ready, 0);

    // All four requesters valid with single-beat bursts: 0,1,2,3,0 with a bubble each.
    vecs[0]  = mk(4'hF, 4'b0001, 2'd0, 1'b0, 66'h00, 0, 1);
    vecs[1]  = mk(4'hF, 4'b0000, 2'd0, 1'b1, 66'h10, 0, 1);
    vecs[2]  = mk(4'hF, 4'b0010, 2'd1, 1'b0, 66'h10, 1, 2);
    vecs[3]  = mk(4'hF, 4'b0000, 2'd1, 1'b1, 66'h20, 1, 2);
    vecs[4]  = mk(4'hF, 4'b0100, 2'd2, 1'b0, 66'h20, 2, 3);
    vecs[5]  = mk(4'hF, 4'b0000, 2'd2, 1'b1, 66'h30, 2, 3);
    vecs[6]  = mk(4'hF, 4'b1000, 2'd3, 1'b0, 66'h30, 3, 4);
    vecs[7]  = mk(4'hF, 4'b0000, 2'd3, 1'b1, 66'h40, 3, 4);
    vecs[8]  = mk(4'hF, 4'b0001, 2'd0, 1'b0, 66'h40, 4, 5);
    vecs[9]  = mk(4'hF, 4'b0000, 2'd0, 1'b1, 66'h10, 4, 5);
    vecs[10] = mk(4'h0, 4'b0000, 2'd0, 1'b0, 66'h10, 5, 5);

    i_rst = 1'b1;
    for (int r = 0; r < NR; r++) set_lanes(r, 66'((r + 1) * 16));
    for (int i = 0; i < 11; i++) begin
      i_req_valid = vecs[i].vld;
      i_req_last  = vecs[i].lst;
      i_chk_ready = vecs[i].rdy;
      tick;
      check($sformatf("rr%0d_grant", i), o_grant, vecs[i].grant);
      check($sformatf("rr%0d_gid", i), o_grant_id, vecs[i].gid);
      check($sformatf("rr%0d_rxv", i), o_rx_valid, vecs[i].rxv);
      check($sformatf("rr%0d_lane0", i), o_rx_coded_0, vecs[i].lane0);
      check($sformatf("rr%0d_beats", i), o_beat_count, vecs[i].beats);
      check($sformatf("rr%0d_sw", i), o_switch_count, vecs[i].sw);
    end

    // Three-beat burst from req0, last beat carries lanes A..D.
    i_rst = 1'b0; i_req_valid = '0; i_req_last = '0;
    tick;
    i_rst = 1'b1;
    i_req_valid = 4'b0001; set_lanes(0, 66'h11);
    tick;
    check("a_grant", o_grant, 4'b0001);
    check("a_sw", o_switch_count, 1);
    check("a_ready", o_req_ready, 4'b0001);
    tick;
    check("a_b1_rxv", o_rx_valid, 1);
    check("a_b1_lane0", o_rx_coded_0, 66'h11);
    set_lanes(0, 66'h21);
    tick;
    check("a_b2_lane0", o_rx_coded_0, 66'h21);
    check("a_b2_beats", o_beat_count, 1);
    set_lanes(0, 66'hA); i_req_last = 4'b0001;
    tick;
    check("a_b3_lane0", o_rx_coded_0, 66'hA);
    check("a_b3_lane1", o_rx_coded_1, 66'hB);
    check("a_b3_lane2", o_rx_coded_2, 66'hC);
    check("a_b3_lane3", o_rx_coded_3, 66'hD);
    check("a_b3_grant", o_grant, 0);
    i_req_valid = '0; i_req_last = '0;
    tick;
    check("a_end_rxv", o_rx_valid, 0);
    check("a_end_beats", o_beat_count, 3);
    check("a_end_sw", o_switch_count, 1);

    // req2 never signals last: forced release after MAX_BURST, then req3.
    set_lanes(2, 66'h200); set_lanes(3, 66'h300);
    i_req_valid = 4'b1100;
    tick;
    check("b_grant2", o_grant, 4'b0100);
    check("b_sw", o_switch_count, 2);
    for (int i = 1; i <= 16; i++) begin
      tick;
      if (i == 15) check("b_hold15", o_grant, 4'b0100);
      if (i == 16) begin
        check("b_rel16", o_grant, 0);
        check("b_lane0", o_rx_coded_0, 66'h200);
        check("b_beats16", o_beat_count, 18);
      end
    end
    tick;
    check("b_grant3", o_grant, 4'b1000);
    check("b_sw3", o_switch_count, 3);
    check("b_beats", o_beat_count, 19);
    check("b_rxv", o_rx_valid, 0);

    // Checker stalls five cycles with beat E pending.
    i_req_valid = 4'b1000; set_lanes(3, 66'hE);
    tick;
    check("c_rxv", o_rx_valid, 1);
    check("c_lane0", o_rx_coded_0, 66'hE);
    i_chk_ready = 1'b0; set_lanes(3, 66'h2E0);
    #1;
    check("c_ready_stall", o_req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("c_stall%0d_rxv", i), o_rx_valid, 1);
      check($sformatf("c_stall%0d_lane0", i), o_rx_coded_0, 66'hE);
      check($sformatf("c_stall%0d_beats", i), o_beat_count, 19);
    end
    i_chk_ready = 1'b1;
    #1;
    check("c_ready_back", o_req_ready, 4'b1000);
    tick;
    check("c_beats", o_beat_count, 20);
    check("c_lane0_next", o_rx_coded_0, 66'h2E0);

    // Reset in the middle of req3's burst, then req0 wins over req1.
    i_rst = 1'b0;
    tick;
    check("d_grant", o_grant, 0);
    check("d_rxv", o_rx_valid, 0);
    check("d_lane0", o_rx_coded_0, 0);
    check("d_beats", o_beat_count, 0);
    check("d_sw", o_switch_count, 0);
    check("d_ready", o_req_ready, 0);
    i_rst = 1'b1; i_req_valid = 4'b0011;
    tick;
    check("d_regrant", o_grant, 4'b0001);
    check("d_regrant_id", o_grant_id, 0);
    check("d_regrant_sw", o_switch_count, 1);
    i_req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/baser_checker_arbiter.md
Name: baser_checker_arbiter

Overview:
- Shares one BASE-R 4x66b checker input port (i_rx_coded_0..3) among NUM_REQ block-stream sources (generator/agent channels).
- Round-robin grant per burst, valid/ready handshake on both sides, one registered output stage toward the checker.
- Keeps beat and grant-switch statistics for the scoreboard.

Parameters:
- FRAME_WIDTH, 66, width of one 66b coded block (2b sync header + 64b payload).
- LANES, 4, coded blocks per beat.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum beats per grant before forced release (1..255).
- TIMEOUT, 32, idle-valid cycles before watchdog release (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-low.
- i_req_valid  in  NUM_REQ  per-requester beat valid.
- i_req_last  in  NUM_REQ  per-requester last beat of burst.
- i_req_data  in  NUM_REQ*LANES*FRAME_WIDTH  requester r occupies slice [r*264 +: 264]; lane k at [k*66 +: 66] within the slice.
- o_req_ready  out  NUM_REQ  per-requester ready.
- o_rx_coded_0  out  FRAME_WIDTH  lane 0 to checker.
- o_rx_coded_1  out  FRAME_WIDTH  lane 1 to checker.
- o_rx_coded_2  out  FRAME_WIDTH  lane 2 to checker.
- o_rx_coded_3  out  FRAME_WIDTH  lane 3 to checker.
- o_rx_valid  out  1  beat valid to checker.
- i_chk_ready  in  1  checker accepts beat.
- o_grant  out  NUM_REQ  one-hot current grant (0 in IDLE).
- o_grant_id  out  $clog2(NUM_REQ)  index of current/last grant.
- o_beat_count  out  32  total beats accepted by the checker.
- o_switch_count  out  32  total grants issued.

Behaviour:
- Reset (i_rst==0 at posedge): state IDLE; all outputs 0; RR pointer 0, so req 0 has highest priority first; burst counter 0.
- States:
  - IDLE: if any i_req_valid, select first valid index at or after the pointer (wrapping), load o_grant/o_grant_id, o_switch_count++, go GRANT. No ready in IDLE.
  - GRANT: forward beats from the granted requester.
  - Release: on the accepted beat with i_req_last=1, or on the accepted beat that makes the burst count equal MAX_BURST, go IDLE; pointer = grant_id+1 mod NUM_REQ; burst counter cleared.
  - One IDLE bubble between consecutive grants, by design.
- Handshake: o_req_ready[g] = (state==GRANT) & o_grant[g] & (!o_rx_valid | i_chk_ready); non-granted ready = 0. Transfer = i_req_valid[g] & o_req_ready[g].
- Output stage:
  - On transfer: lanes register the granted slice and o_rx_valid=1 (latency 1 cycle).
  - If no transfer and i_chk_ready: o_rx_valid=0 and lanes hold their last value.
  - Beat held stable while o_rx_valid & !i_chk_ready.
- o_beat_count increments on o_rx_valid & i_chk_ready.
- Counters wrap 0xFFFFFFFF->0 silently.
- The requester's valid may drop mid-burst; the grant is held (no release without last/MAX_BURST unless the watchdog is enabled).
- A pending output beat is never dropped on grant change; it drains before or concurrently with the next grant.
- Reset mid-burst: outputs, pending beat, state and counters cleared immediately.
- Single requester permanently valid: re-granted after each bubble.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: in GRANT, count consecutive cycles with i_req_valid[g]==0; at TIMEOUT, release to IDLE as for last, advance pointer, pulse extra output o_timeout (1b, 1 cycle).
- Undefined: no counter, no o_timeout port; grant is held indefinitely.

Decomposition:
- Package baser_arb_pkg: state enum (ARB_IDLE, ARB_GRANT), LANES=4, FRAME_WIDTH=66, BEAT_WIDTH=LANES*FRAME_WIDTH, counter width 32.
- Sub-module rr_pick: combinational rotating-priority picker (inputs req vector, pointer; outputs one-hot + index + any).

Test Plan:
- Reset then req0 valid, 3 beats, last on beat 3 with lanes 66'hA..66'hD, i_chk_ready=1 -> o_grant=4'b0001 one cycle after valid; lanes 66'hA,B,C,D on o_rx_coded_0..3 one cycle after each transfer; o_beat_count=3, o_switch_count=1.
- All 4 requesters valid, each 1-beat bursts (last=1) -> grant order 0,1,2,3,0 with one IDLE cycle between; o_switch_count=5 after 5 grants.
- req2 valid, last never asserted, MAX_BURST=16 -> forced release after 16th accepted beat; next grant goes to req3 if valid.
- i_chk_ready=0 for 5 cycles with beat 66'hE pending -> o_rx_valid=1 and data stable, o_req_ready[g]=0, no beat_count change; beat counted on the cycle ready returns.
- i_rst=0 asserted mid-burst (beat 2 of 4) -> next cycle all outputs 0, state IDLE, pointer 0; req1 and req0 both valid afterwards -> req0 granted.
- ARB_TIMEOUT_EN, TIMEOUT=32: granted req1 drops valid -> o_timeout pulses on 32nd idle cycle, o_grant=0 the next cycle.
